// File: rtl/arc4_pkg.sv
// Shared types, constants and helpers for the ARC4 encryptor.
package arc4_pkg;

    localparam int KEY_W     = 24;
    localparam int MSG_MAX   = 255;
    localparam int KEY_BYTES = 3;

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RDI,
        KSA_SUM,
        KSA_RDJ,
        KSA_WRI,
        KSA_WRJ,
        LEN,
        LEN_WR,
        PRGA_RDI,
        PRGA_SUM,
        PRGA_RDJ,
        PRGA_WRI,
        PRGA_WRJ,
        PRGA_RDP,
        PRGA_WRC,
        DONE
    } state_t;

    // Key byte 0 is the most significant byte of the key word.
    function automatic logic [7:0] keybyte(input logic [KEY_W-1:0] key, input logic [1:0] idx);
        case (idx)
            2'd0:    keybyte = key[23:16];
            2'd1:    keybyte = key[15:8];
            default: keybyte = key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Handshake and memory-port bundle of the ARC4 encryptor.
interface arc4_encrypt_if;
    import arc4_pkg::*;

    logic             en;
    logic             rdy;
    logic [KEY_W-1:0] key;
    logic [7:0]       s_addr;
    logic [7:0]       s_rddata;
    logic [7:0]       s_wrdata;
    logic             s_wren;
    logic [7:0]       pt_addr;
    logic [7:0]       pt_rddata;
    logic [7:0]       ct_addr;
    logic [7:0]       ct_wrdata;
    logic             ct_wren;

    // master: the encryptor, which owns all memory addresses and write strobes
    modport master (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );

    // slave: the surrounding memories and the requester
    modport slave (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );

endinterface

// File: rtl/arc4_sinit.sv
// Identity fill of the S-box: writes S[i]=i for i=0..255, one write per cycle.
module arc4_sinit (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       wren
);
    logic       busy;
    logic [7:0] cnt;

    // Fill counter: starts on en while idle, stops after the write at 255 wraps it to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= 8'h00;
        end else if (!busy && en) begin
            busy <= 1'b1;
            cnt  <= 8'h00;
        end else if (busy) begin
            cnt <= cnt + 8'h01;
            if (cnt == 8'hFF) busy <= 1'b0;
        end
    end

    assign rdy    = !busy;
    assign wren   = busy;
    assign addr   = cnt;
    assign wrdata = cnt;

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: identity fill, key schedule, then keystream XOR of a
// length-prefixed plaintext into a length-prefixed ciphertext image.
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    arc4_encrypt_if.master bus
);
    state_t           state, state_nxt;
    logic [KEY_W-1:0] key_q;
    logic [7:0]       i, j, k, len, si, sj;
    logic [1:0]       kidx;
    logic             sinit_en, sinit_rdy, sinit_wren;
    logic [7:0]       sinit_addr, sinit_wrdata;

    assign sinit_en = (state == IDLE) && bus.en;

    arc4_sinit u_sinit (
        .clk    (clk),
        .rst    (rst),
        .en     (sinit_en),
        .rdy    (sinit_rdy),
        .addr   (sinit_addr),
        .wrdata (sinit_wrdata),
        .wren   (sinit_wren)
    );

    // State register; reset aborts any operation immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and memory port drive; every read's data is consumed in the following state
    always_comb begin
        state_nxt     = state;
        bus.rdy       = 1'b0;
        bus.s_addr    = 8'h00;
        bus.s_wrdata  = 8'h00;
        bus.s_wren    = 1'b0;
        bus.pt_addr   = 8'h00;
        bus.ct_addr   = 8'h00;
        bus.ct_wrdata = 8'h00;
        bus.ct_wren   = 1'b0;
        case (state)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) state_nxt = INIT;
            end
            INIT: begin
                bus.s_addr   = sinit_addr;
                bus.s_wrdata = sinit_wrdata;
                bus.s_wren   = sinit_wren;
                if (sinit_rdy) state_nxt = KSA_RDI;
            end
            KSA_RDI: begin
                bus.s_addr = i;
                state_nxt  = KSA_SUM;
            end
            KSA_SUM: state_nxt = KSA_RDJ;
            KSA_RDJ: begin
                bus.s_addr = j;
                state_nxt  = KSA_WRI;
            end
            KSA_WRI: begin
                bus.s_addr   = i;
                bus.s_wrdata = bus.s_rddata;
                bus.s_wren   = 1'b1;
                state_nxt    = KSA_WRJ;
            end
            KSA_WRJ: begin
                bus.s_addr   = j;
                bus.s_wrdata = si;
                bus.s_wren   = 1'b1;
                state_nxt    = (i == 8'hFF) ? LEN : KSA_RDI;
            end
            LEN: begin
                bus.pt_addr = 8'h00;
                state_nxt   = LEN_WR;
            end
            LEN_WR: begin
                bus.ct_addr   = 8'h00;
                bus.ct_wrdata = bus.pt_rddata;
                bus.ct_wren   = 1'b1;
                state_nxt     = (bus.pt_rddata == 8'h00) ? DONE : PRGA_RDI;
            end
            PRGA_RDI: begin
                bus.s_addr = i;
                state_nxt  = PRGA_SUM;
            end
            PRGA_SUM: state_nxt = PRGA_RDJ;
            PRGA_RDJ: begin
                bus.s_addr = j;
                state_nxt  = PRGA_WRI;
            end
            PRGA_WRI: begin
                bus.s_addr   = i;
                bus.s_wrdata = bus.s_rddata;
                bus.s_wren   = 1'b1;
                state_nxt    = PRGA_WRJ;
            end
            PRGA_WRJ: begin
                bus.s_addr   = j;
                bus.s_wrdata = si;
                bus.s_wren   = 1'b1;
                state_nxt    = PRGA_RDP;
            end
            PRGA_RDP: begin
                // post-swap S[i]+S[j] equals the pre-swap sum, so no re-read is needed
                bus.s_addr  = si + sj;
                bus.pt_addr = k;
                state_nxt   = PRGA_WRC;
            end
            PRGA_WRC: begin
                bus.ct_addr   = k;
                bus.ct_wrdata = bus.pt_rddata ^ bus.s_rddata;
                bus.ct_wren   = 1'b1;
                state_nxt     = (k == len) ? DONE : PRGA_RDI;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: indices, swap holding values, key and message length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
            i     <= 8'h00;
            j     <= 8'h00;
            k     <= 8'h00;
            len   <= 8'h00;
            si    <= 8'h00;
            sj    <= 8'h00;
            kidx  <= 2'd0;
        end else begin
            case (state)
                IDLE: if (bus.en) begin
                    key_q <= bus.key;
                    i     <= 8'h00;
                    j     <= 8'h00;
                    kidx  <= 2'd0;
                end
                KSA_SUM: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata + keybyte(key_q, kidx);
                end
                KSA_WRJ: begin
                    i    <= i + 8'h01;
                    kidx <= (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
                end
                LEN_WR: begin
                    len <= bus.pt_rddata;
                    i   <= 8'h01;
                    j   <= 8'h00;
                    k   <= 8'h01;
                end
                PRGA_SUM: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata;
                end
                PRGA_WRI: sj <= bus.s_rddata;
                PRGA_WRC: begin
                    k <= k + 8'h01;
                    i <= i + 8'h01;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for the ARC4 encryptor: memory models, a software ARC4 reference,
// a per-cycle ct write checker and directed plus randomized jobs.
module tb_arc4_encrypt;
    import arc4_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arc4_encrypt_if bus ();
    arc4_encrypt dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] exp_ct [256];
    logic [7:0] exp_s  [256];
    int exp_len   = 0;
    int ct_writes = 0;
    int n_cmp     = 0;
    int n_bad     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Synchronous memories with one-cycle read latency
    always @(posedge clk) begin
        bus.s_rddata  <= s_mem[bus.s_addr];
        if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
        bus.pt_rddata <= pt_mem[bus.pt_addr];
        if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
    end

    // Every ct write must be the next byte of the reference ciphertext, in order
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.en && bus.rdy) ct_writes = 0;
            else if (bus.ct_wren) begin
                check("ct_addr", {24'h0, bus.ct_addr}, ct_writes);
                if (ct_writes <= exp_len)
                    check("ct_data", {24'h0, bus.ct_wrdata}, {24'h0, exp_ct[ct_writes]});
                ct_writes++;
            end
        end
    end

    // Plain software ARC4 over pt_mem; fills exp_ct and exp_s
    task automatic model(input logic [23:0] key, input int len);
        int s[256];
        int kb[3];
        int a, b, t;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int n = 0; n < 256; n++) s[n] = n;
        b = 0;
        for (int n = 0; n < 256; n++) begin
            b = (b + s[n] + kb[n % 3]) % 256;
            t = s[n]; s[n] = s[b]; s[b] = t;
        end
        exp_ct[0] = 8'(len);
        a = 0;
        b = 0;
        for (int n = 1; n <= len; n++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            t = s[a]; s[a] = s[b]; s[b] = t;
            exp_ct[n] = pt_mem[n] ^ 8'(s[(s[a] + s[b]) % 256]);
        end
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(s[n]);
        exp_len = len;
    endtask

    task automatic load_text(input string txt);
        pt_mem[0] = 8'(txt.len());
        for (int n = 0; n < txt.len(); n++) pt_mem[n + 1] = txt[n];
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rdy"}, {31'h0, bus.rdy}, 32'h1);
        check({tag, "_wren"}, {30'h0, bus.s_wren, bus.ct_wren}, 32'h0);
        check({tag, "_addr"}, {8'h0, bus.s_addr, bus.pt_addr, bus.ct_addr}, 32'h0);
        check({tag, "_wrdata"}, {16'h0, bus.s_wrdata, bus.ct_wrdata}, 32'h0);
    endtask

    task automatic run_job(input logic [23:0] key, input bit extra_en);
        int len, cyc, bound, errs;
        len   = int'(pt_mem[0]);
        model(key, len);
        bound = 1798 + 8 * len + 10;
        @(posedge clk); #1;
        bus.key = key;
        bus.en  = 1'b1;
        @(posedge clk); #1;
        bus.en  = 1'b0;
        @(negedge clk);
        check("rdy_low", {31'h0, bus.rdy}, 32'h0);
        cyc = 0;
        while (bus.rdy !== 1'b1 && cyc < bound) begin
            if (extra_en) begin
                bus.en = ((cyc >= 100 && cyc < 110) || (cyc >= 1600 && cyc < 1606));
                if (bus.en) bus.key = 24'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.en = 1'b0;
        check("rdy_return", {31'h0, bus.rdy}, 32'h1);
        check("ct_count", ct_writes, len + 1);
        errs = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) errs++;
        check("s_final", errs, 0);
        errs = 0;
        for (int n = 0; n <= len; n++) if (ct_mem[n] !== exp_ct[n]) errs++;
        check("ct_image", errs, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] kv [10];
        string txt;
        int len;
        kv = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        bus.en  = 1'b0;
        bus.key = '0;
        repeat (2) @(negedge clk);
        reset_checks("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Known vector, model pinned against literal ciphertext
        load_text("Plaintext");
        model(24'h4B6579, 9);
        for (int n = 0; n < 10; n++) check("model_kv", {24'h0, exp_ct[n]}, {24'h0, kv[n]});
        run_job(24'h4B6579, 1'b0);
        for (int n = 0; n < 10; n++) check("dut_kv", {24'h0, ct_mem[n]}, {24'h0, kv[n]});

        // Zero length
        pt_mem[0] = 8'h00;
        run_job(24'h000000, 1'b0);

        // Round trip
        txt = "HELLO";
        load_text(txt);
        run_job(24'h1A2B3C, 1'b0);
        for (int n = 0; n < 6; n++) pt_mem[n] = ct_mem[n];
        run_job(24'h1A2B3C, 1'b0);
        check("rt_len", {24'h0, ct_mem[0]}, 32'd5);
        for (int n = 1; n <= 5; n++) check("rt_text", {24'h0, ct_mem[n]}, {24'h0, txt[n - 1]});

        // Reset during KSA, then the known vector again
        load_text("Plaintext");
        @(posedge clk); #1;
        bus.key = 24'h4B6579;
        bus.en  = 1'b1;
        @(posedge clk); #1;
        bus.en  = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        reset_checks("abort");
        check("abort_no_ct", ct_writes, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(24'h4B6579, 1'b0);
        for (int n = 0; n < 10; n++) check("dut_kv_after_abort", {24'h0, ct_mem[n]}, {24'h0, kv[n]});

        // en pulses (with a different key) while busy must be ignored
        pt_mem[0] = 8'd40;
        for (int n = 1; n <= 40; n++) pt_mem[n] = 8'($urandom);
        run_job(24'($urandom), 1'b1);

        // Random messages
        for (int r = 0; r < 4; r++) begin
            len = (r == 0) ? 1 : int'($urandom_range(2, 60));
            pt_mem[0] = 8'(len);
            for (int n = 1; n <= len; n++) pt_mem[n] = 8'($urandom);
            run_job(24'($urandom), 1'b0);
        end

        // Maximum length, all-zero plaintext: ciphertext is the raw keystream
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'h00;
        run_job(24'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
